fib_controller: RTL and testbench

Control FSM for the gate-level Fibonacci engine. It sits directly upstream of the Fibonacci datapath and drives that datapath's stack, register, subtract-select and counter strobes from `start` and the datapath status lines (`lt`, `empty`, `d`). The algorithm is an explicit-stack recursion: each value popped from the stack is either counted as a leaf or expanded into its n-1 and n-2 children. The leaf count left in the datapath counter is the result.

---
 rtl/fib_controller_if.sv | 32 +++
 rtl/fib_controller.sv | 134 +++++++++++++
 tb/tb_fib_controller.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_controller_if.sv
// Control/status bundle between fib_controller and the Fibonacci datapath.
//   start, lt, empty, d           : request and datapath status into the controller
//   dp_rst, push, pop, ld, is, fs : datapath strobes out of the controller
//   inc                           : leaf counter increment
//   busy, done, err               : computation status
// The master modport is the controller's view; slave is the datapath/requester view.
interface fib_controller_if;
  logic start;
  logic lt;
  logic empty;
  logic d;
  logic dp_rst;
  logic push;
  logic pop;
  logic ld;
  logic is;
  logic fs;
  logic inc;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start, lt, empty, d,
    output dp_rst, push, pop, ld, is, fs, inc, busy, done, err
  );

  modport slave (
    output start, lt, empty, d,
    input  dp_rst, push, pop, ld, is, fs, inc, busy, done, err
  );
endinterface

// File: rtl/fib_controller.sv
// Control FSM for the gate-level Fibonacci engine. It walks an explicit stack:
// each popped value is either counted as a leaf (< 2) or expanded into its
// n-1 and n-2 children. The datapath leaf counter holds the result at done.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   dp_io : fib_controller_if.master (start/status in, strobes/status out)
// Strobes are decoded combinationally from state (Mealy in CHECK and on start
// in IDLE/DONE); busy, done and err are registered.
module fib_controller (
  input  logic             clk,
  input  logic             rst,
  fib_controller_if.master dp_io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_EXP1  = 3'd3,
    S_EXP2  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic dp_rst_c, push_c, pop_c, ld_c, is_c, fs_c, inc_c;

  // State and status flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; busy/done are registered from the next state so they
  // line up exactly with the state they describe.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (dp_io.start) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
        end
      end
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        // Overflow wins over empty, empty wins over the leaf test
        if (dp_io.d) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (dp_io.empty) begin
          state_d = S_DONE;
        end else if (!dp_io.lt) begin
          state_d = S_EXP1;
        end
      end
      S_EXP1:  state_d = S_EXP2;
      S_EXP2:  state_d = S_CHECK;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_CHECK) ||
             (state_d == S_EXP1) || (state_d == S_EXP2);
    done_d = (state_d == S_DONE);
  end

  // Strobe decode; rst suppresses every strobe in the cycle it is asserted
  always_comb begin
    dp_rst_c = 1'b0;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    ld_c     = 1'b0;
    is_c     = 1'b0;
    fs_c     = 1'b0;
    inc_c    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          dp_rst_c = dp_io.start;
        end
        S_LOAD: begin
          push_c = 1'b1;
        end
        S_CHECK: begin
          if (!dp_io.d && !dp_io.empty) begin
            pop_c = 1'b1;
            if (dp_io.lt) begin
              inc_c = 1'b1;
            end else begin
              ld_c = 1'b1;
            end
          end
        end
        S_EXP1: begin
          push_c = 1'b1;
          is_c   = 1'b1;
          fs_c   = 1'b1;
        end
        S_EXP2: begin
          push_c = 1'b1;
          is_c   = 1'b1;
        end
        default: begin
          dp_rst_c = 1'b0;
        end
      endcase
    end
  end

  assign dp_io.dp_rst = dp_rst_c;
  assign dp_io.push   = push_c;
  assign dp_io.pop    = pop_c;
  assign dp_io.ld     = ld_c;
  assign dp_io.is     = is_c;
  assign dp_io.fs     = fs_c;
  assign dp_io.inc    = inc_c;
  assign dp_io.busy   = busy_q;
  assign dp_io.done   = done_q;
  assign dp_io.err    = err_q;

endmodule

// File: tb/tb_fib_controller.sv
// Bench for fib_controller: a behavioural stack/register/counter datapath model
// closes the loop; a scoreboard of hand-computed results is checked whenever
// done rises.
`timescale 1ns/1ps
module tb_fib_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fib_controller_if ifc();

  fib_controller dut (
    .clk   (clk),
    .rst   (rst),
    .dp_io (ifc)
  );

  // Strobe words {dp_rst,push,pop,ld,is,fs,inc}
  localparam logic [6:0] W_PUSHN  = 7'b0100000;
  localparam logic [6:0] W_POPLD  = 7'b0011000;
  localparam logic [6:0] W_PUSH1  = 7'b0100110;
  localparam logic [6:0] W_PUSH2  = 7'b0100100;
  localparam logic [6:0] W_POPINC = 7'b0010001;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- datapath model ----------------
  logic [2:0] n_val   = 3'd0;
  logic [2:0] stk [0:31];
  logic [4:0] sp      = 5'd0;
  logic [2:0] reg_q   = 3'd0;
  logic [4:0] cnt     = 5'd0;
  logic       ovf     = 1'b0;
  logic       force_d = 1'b0;
  logic [2:0] top_v;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.dp_rst) begin
      cnt   <= 5'd0;
      reg_q <= 3'd0;
      ovf   <= 1'b0;
      sp    <= 5'd0;
    end else begin
      if (ifc.push && sp != 5'd31) begin
        stk[sp] <= ifc.is ? (reg_q - (ifc.fs ? 3'd1 : 3'd2)) : n_val;
        sp      <= sp + 5'd1;
      end
      if (ifc.pop && sp != 5'd0) sp <= sp - 5'd1;
      if (ifc.ld && sp != 5'd0) reg_q <= stk[sp - 5'd1];
      if (ifc.inc) begin
        if (cnt == 5'd31) ovf <= 1'b1;
        cnt <= cnt + 5'd1;
      end
    end
  end

  always_comb top_v = stk[sp - 5'd1];
  assign ifc.empty = (sp == 5'd0);
  assign ifc.lt    = (sp != 5'd0) && (top_v < 3'd2);
  assign ifc.d     = ovf | force_d;

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          exp_res;
    bit          chk_res;
    int          exp_cyc;
    int          exp_err;
    int          exp_busy;
    int          seq_len;
    logic [41:0] seq;
    int          t_set;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input string nm, input int res, input bit cr,
                              input int cy, input int er, input int bz,
                              input int len, input logic [41:0] sq);
    exp_t e;
    e.name = nm; e.exp_res = res; e.chk_res = cr; e.exp_cyc = cy;
    e.exp_err = er; e.exp_busy = bz; e.seq_len = len; e.seq = sq; e.t_set = 0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic       done_p = 1'b0;
  logic       busy_p = 1'b0;
  int         busy_cnt = 0;
  logic [6:0] trace[$];
  logic [6:0] mw;
  logic [6:0] sw;
  exp_t       me;

  always @(negedge clk) begin
    mw = {ifc.dp_rst, ifc.push, ifc.pop, ifc.ld, ifc.is, ifc.fs, ifc.inc};
    if (ifc.busy && !busy_p) begin
      trace.delete();
      busy_cnt = 0;
    end
    if (ifc.busy) begin
      busy_cnt++;
      if (mw != 7'd0) trace.push_back(mw);
    end
    if (ifc.done && !done_p) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: done rose with no expected entry");
      end else begin
        me = sb.pop_front();
        chk({me.name, "_cycles"}, cyc - me.t_set, me.exp_cyc);
        chk({me.name, "_err"}, int'(ifc.err), me.exp_err);
        chk({me.name, "_busy_excl"}, int'(ifc.busy), 0);
        if (me.chk_res) chk({me.name, "_result"}, int'(cnt), me.exp_res);
        if (me.exp_busy >= 0) chk({me.name, "_busy_len"}, busy_cnt, me.exp_busy);
        if (me.seq_len >= 0) begin
          chk({me.name, "_seq_len"}, trace.size(), me.seq_len);
          for (int i = 0; i < me.seq_len && i < trace.size(); i++) begin
            sw = me.seq[7*i +: 7];
            chk($sformatf("%s_seq%0d", me.name, i), int'(trace[i]), int'(sw));
          end
        end
      end
    end
    done_p = ifc.done;
    busy_p = ifc.busy;
  end

  // ---------------- stimulus ----------------
  task automatic start_run(input logic [2:0] n, input bit hold, input bit use_sb, input exp_t e);
    @(negedge clk);
    n_val     = n;
    force_d   = 1'b0;
    ifc.start = 1'b1;
    e.t_set   = cyc;
    if (use_sb) sb.push_back(e);
    #1 chk({e.name, "_dp_rst"}, int'(ifc.dp_rst), 1);
    @(negedge clk);
    if (!hold) ifc.start = 1'b0;
    chk({e.name, "_busy_start"}, int'(ifc.busy), 1);
    chk({e.name, "_err_clr"}, int'(ifc.err), 0);
  endtask

  task automatic wait_done(input string nm, input int max);
    int k = 0;
    while (!ifc.done && k < max) begin
      @(negedge clk);
      k++;
    end
    if (!ifc.done) begin
      total++; bad++;
      $display("FAIL %s_timeout: done=%0d after %0d cycles expected 1", nm, ifc.done, k);
    end
  endtask

  initial begin
    logic [9:0] outs;
    exp_t       e;
    ifc.start = 1'b1;
    n_val     = 3'd3;

    // Reset held two cycles with start high: everything quiet
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      outs = {ifc.dp_rst, ifc.push, ifc.pop, ifc.ld, ifc.is, ifc.fs, ifc.inc,
              ifc.busy, ifc.done, ifc.err};
      chk($sformatf("reset_outs%0d", i), int'(outs), 0);
    end
    @(negedge clk);
    rst       = 1'b0;
    ifc.start = 1'b0;

    e = mk("n3", 3, 1'b1, 12, 0, 11, -1, 42'd0);
    start_run(3'd3, 1'b0, 1'b1, e);
    wait_done("n3", 200);

    e = mk("n0", 1, 1'b1, 4, 0, 3, 2, {28'd0, W_POPINC, W_PUSHN});
    start_run(3'd0, 1'b0, 1'b1, e);
    wait_done("n0", 200);

    e = mk("n1", 1, 1'b1, 4, 0, 3, 2, {28'd0, W_POPINC, W_PUSHN});
    start_run(3'd1, 1'b0, 1'b1, e);
    wait_done("n1", 200);

    e = mk("n2", 2, 1'b1, 8, 0, 7, 6,
           {W_POPINC, W_POPINC, W_PUSH2, W_PUSH1, W_POPLD, W_PUSHN});
    start_run(3'd2, 1'b0, 1'b1, e);
    wait_done("n2", 200);

    e = mk("n7", 21, 1'b1, 84, 0, 83, -1, 42'd0);
    start_run(3'd7, 1'b0, 1'b1, e);
    wait_done("n7", 300);

    // Restart straight out of DONE
    e = mk("n5_restart", 8, 1'b1, 32, 0, 31, -1, 42'd0);
    start_run(3'd5, 1'b0, 1'b1, e);
    wait_done("n5_restart", 200);

    // start held high throughout: no early restart, then restart right after DONE
    e = mk("n4_held", 5, 1'b1, 20, 0, 19, -1, 42'd0);
    start_run(3'd4, 1'b1, 1'b1, e);
    wait_done("n4_held", 200);
    @(negedge clk);
    chk("n4_held_restart_busy", int'(ifc.busy), 1);
    chk("n4_held_restart_done", int'(ifc.done), 0);
    ifc.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Overflow forced from cycle 10 of an N=6 run (EXP2); next CHECK takes it
    e = mk("n6_ovf", 0, 1'b0, 12, 1, -1, -1, 42'd0);
    start_run(3'd6, 1'b0, 1'b1, e);
    repeat (9) @(negedge clk);
    force_d = 1'b1;
    wait_done("n6_ovf", 200);

    // Reset mid-run of N=7
    e = mk("n7_abort", 0, 1'b0, 0, 0, -1, -1, 42'd0);
    start_run(3'd7, 1'b0, 1'b0, e);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_strobes_in_rst",
           int'({ifc.dp_rst, ifc.push, ifc.pop, ifc.ld, ifc.is, ifc.fs, ifc.inc}), 0);
    @(negedge clk);
    chk("abort_busy", int'(ifc.busy), 0);
    chk("abort_done", int'(ifc.done), 0);
    chk("abort_err", int'(ifc.err), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet%0d", i), int'({ifc.push, ifc.pop, ifc.inc}), 0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
